// File: rtl/recon_mb_scheduler.sv
// Round-robin scheduler that time-shares one Reconstruct instance between
// NUM_REQ requesters: grant, start pulse, watchdog-guarded run, response.
module recon_mb_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rc_start,
    output logic [NUM_REQ-1:0]       rc_sel,
    input  logic                     rc_done,
    input  logic [30:0]              rc_nz,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [30:0]              rsp_nz,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     err_spurious
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [TO_W-1:0]     watchdog_reg;
    logic [NUM_REQ-1:0]  rc_sel_reg;
    logic [ID_W-1:0]     rsp_id_reg;
    logic [TAG_W-1:0]    rsp_tag_reg;
    logic [30:0]         rsp_nz_reg;
    logic                rsp_timeout_reg;
    logic                err_spurious_reg;

    logic [TAG_W-1:0]    tag_arr [NUM_REQ];
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     rr_next;
    logic                wd_expired;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tag
        assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
    end

    // Scan from the round-robin pointer upward, wrapping, and take the first valid.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_onehot = NUM_REQ'(1) << grant_idx;
    assign rr_next      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign wd_expired   = (watchdog_reg == TO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rc_start   = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    req_ready  = grant_onehot;
                    state_next = START;
                end
            end
            START: begin
                rc_start   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (rc_done || wd_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg       <= '0;
            watchdog_reg     <= '0;
            rc_sel_reg       <= '0;
            rsp_id_reg       <= '0;
            rsp_tag_reg      <= '0;
            rsp_nz_reg       <= '0;
            rsp_timeout_reg  <= 1'b0;
            err_spurious_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        rsp_id_reg  <= grant_idx;
                        rsp_tag_reg <= tag_arr[grant_idx];
                        rc_sel_reg  <= grant_onehot;
                        rr_ptr_reg  <= rr_next;
                    end
                end
                START: watchdog_reg <= '0;
                RUN: begin
                    watchdog_reg <= watchdog_reg + TO_W'(1);
                    // A done arriving on the expiry cycle still counts as a good result.
                    if (rc_done) begin
                        rsp_nz_reg      <= rc_nz;
                        rsp_timeout_reg <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_nz_reg      <= '0;
                        rsp_timeout_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rc_sel_reg <= '0;
                    end
                end
                default: ;
            endcase
            if (rc_done && state_reg != RUN) begin
                err_spurious_reg <= 1'b1;
            end
        end
    end

    assign rc_sel       = rc_sel_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_tag      = rsp_tag_reg;
    assign rsp_nz       = rsp_nz_reg;
    assign rsp_timeout  = rsp_timeout_reg;
    assign busy         = (state_reg != IDLE);
    assign err_spurious = err_spurious_reg;

endmodule

// File: tb/tb_recon_mb_scheduler.sv
// Directed and randomized bench for recon_mb_scheduler; a per-run model predicts
// grant order, captured tag, nz/timeout outcome and cycle-level response timing.
module tb_recon_mb_scheduler;

    localparam int TO = 47;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_tag;
    logic [1:0]  req_ready;
    logic        rc_start;
    logic [1:0]  rc_sel;
    logic        rc_done;
    logic [30:0] rc_nz;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [3:0]  rsp_tag;
    logic [30:0] rsp_nz;
    logic        rsp_timeout;
    logic        busy;
    logic        err_spurious;

    int total = 0;
    int bad   = 0;
    int rr_model = 0;

    recon_mb_scheduler #(
        .NUM_REQ(2), .ID_W(1), .TAG_W(4), .TIMEOUT(TO), .TO_W(10)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .rc_start(rc_start), .rc_sel(rc_sel), .rc_done(rc_done), .rc_nz(rc_nz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_nz(rsp_nz), .rsp_timeout(rsp_timeout),
        .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; req_tag = '0; rc_done = 1'b0;
        rc_nz = '0; rsp_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        rr_model = 0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_start", rc_start, 0);
        chk("rst_sel", rc_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_nz", rsp_nz, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_spurious, 0);
    endtask

    // One full transaction. done_at is the RUN-relative cycle of rc_done
    // (0 = first RUN cycle); anything outside 0..TO means it never arrives.
    // pend is the req_valid pattern presented from START onward.
    task automatic run(input logic [1:0] valid, input logic [7:0] tags, input logic [1:0] pend,
                       input int done_at, input logic [30:0] nz, input int hold);
        int g;
        logic [1:0]  onehot;
        logic [3:0]  etag;
        logic [30:0] enz;
        logic        eto;
        logic [1:0]  vtmp;
        vtmp = valid;
        g = -1;
        for (int i = 0; i < 2; i++) begin
            if (g < 0 && vtmp[(rr_model + i) % 2]) g = (rr_model + i) % 2;
        end
        onehot = (g == 0) ? 2'b01 : 2'b10;
        etag   = (g == 0) ? tags[3:0] : tags[7:4];
        if (done_at >= 0 && done_at <= TO) begin
            enz = nz; eto = 1'b0;
        end else begin
            enz = '0; eto = 1'b1;
        end

        req_valid = valid; req_tag = tags; rc_done = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("accept_ready", req_ready, onehot);
        chk("accept_busy", busy, 0);
        tick;
        req_valid = pend;
        req_tag = 8'($urandom);
        #1;
        chk("start_pulse", rc_start, 1);
        chk("start_sel", rc_sel, onehot);
        chk("start_ready", req_ready, 0);
        tick;
        for (int k = 0; k <= TO; k++) begin
            rc_done = (k == done_at);
            rc_nz = rc_done ? nz : 31'($urandom);
            #1;
            chk("run_start_low", rc_start, 0);
            chk("run_rsp_valid", rsp_valid, 0);
            if (k == 0) chk("run_sel", rc_sel, onehot);
            tick;
            if (k == done_at) break;
        end
        rc_done = 1'b0;
        rc_nz = 31'($urandom);
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            #1;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, g);
            chk("rsp_tag", rsp_tag, etag);
            chk("rsp_nz", rsp_nz, enz);
            chk("rsp_timeout", rsp_timeout, eto);
            chk("rsp_ready_block", req_ready, 0);
            chk("rsp_sel", rc_sel, onehot);
            tick;
        end
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_sel", rc_sel, 0);
        chk("post_busy", busy, 0);
        rr_model = (g + 1) % 2;
        $display("run grant=%0d tag=%0h nz=%0h timeout=%0d hold=%0d", g, etag, enz, eto, hold);
    endtask

    initial begin
        do_reset;

        // single request, done 40 cycles after start
        run(2'b01, 8'h05, 2'b00, 39, 31'h00010003, 0);

        // both held: grants 0,1,0 from a fresh pointer
        do_reset;
        run(2'b11, 8'h3A, 2'b11, 5, 31'h1234, 0);
        run(2'b11, 8'h7C, 2'b11, 9, 31'h5678, 1);
        run(2'b11, 8'h9E, 2'b00, 2, 31'h7FFFFFFF, 0);

        // watchdog expiry with no done, and done on the expiry cycle
        run(2'b10, 8'hB0, 2'b00, -1, 31'h1111, 0);
        run(2'b01, 8'h0C, 2'b00, TO, 31'h2222, 0);
        run(2'b01, 8'h0D, 2'b00, TO - 1, 31'h3333, 0);

        // response stalled 10 cycles with req1 waiting, then req1 next
        run(2'b01, 8'h42, 2'b10, 3, 31'h4444, 10);
        run(2'b10, 8'h6F, 2'b00, 4, 31'h5555, 0);

        for (int n = 0; n < 20; n++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run(v, 8'($urandom), 2'($urandom), $urandom_range(0, TO + 3),
                31'($urandom), $urandom_range(0, 3));
        end
        req_valid = '0;
        chk("no_spurious_yet", err_spurious, 0);

        // reset in the middle of a run, then a stray done
        req_valid = 2'b01;
        tick;
        req_valid = '0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sel", rc_sel, 0);
        chk("midrst_start", rc_start, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_err", err_spurious, 0);
        rc_done = 1'b1;
        rc_nz = 31'h1;
        tick;
        rc_done = 1'b0;
        #1;
        chk("spurious_err", err_spurious, 1);
        chk("spurious_busy", busy, 0);
        chk("spurious_rsp_valid", rsp_valid, 0);
        tick;
        chk("spurious_sticky", err_spurious, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
